acca_mul_pipe: RTL and testbench

- Parametrised, pipelined successor to the fixed 8x8 quadrant-split approximate multiplier.
- Each operand is split into high and low halves, giving four sub-products (HH, HL, LH, LL).
- A per-transaction 4-bit mask selects, for each quadrant, an exact or a truncated (approximate) sub-product; the four are then accumulated.
- Sits between operand producers and accuracy-tolerant consumers (filters, MAC arrays); valid/ready on both sides.

---
 rtl/acca_mul_pipe_if.sv | 34 +++
 rtl/acca_mul_pipe.sv | 181 ++++++++++++++++++
 tb/tb_acca_mul_pipe.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acca_mul_pipe_if.sv
// ----------------------------------------------------------------------------
// acca_mul_pipe_if
// Operand / product handshake bundle for acca_mul_pipe.
//   in_valid  : producer -> block, operand transfer request
//   in_ready  : block -> producer, block can accept operands
//   in_a/in_b : producer -> block, unsigned operands (W bits)
//   in_mode   : producer -> block, per-quadrant approximation mask
//   out_valid : block -> consumer, product available
//   out_ready : consumer -> block, product accepted
//   out_prod  : block -> consumer, product (2W bits)
// master = operand producer / product consumer side, slave = the multiplier.
// ----------------------------------------------------------------------------
interface acca_mul_pipe_if #(
    parameter int W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [3:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   out_prod;

    modport master (
        output in_valid, in_a, in_b, in_mode, out_ready,
        input  in_ready, out_valid, out_prod
    );

    modport slave (
        input  in_valid, in_a, in_b, in_mode, out_ready,
        output in_ready, out_valid, out_prod
    );
endinterface

// File: rtl/acca_mul_pipe.sv
// ----------------------------------------------------------------------------
// acca_mul_pipe
// Three-stage pipelined quadrant-split approximate multiplier.
// Each operand is split into high/low halves; the four half-width
// sub-products are individually exact or truncated (low TRUNC bits zeroed)
// according to a per-transaction mask, then accumulated.
//
// Ports:
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   bus      : acca_mul_pipe_if.slave (valid/ready operands in, product out)
//   err_clr  : synchronous clear of the error monitor      (ACCA_ERR_MON_EN)
//   err_acc  : saturating sum of (exact - approx)           (ACCA_ERR_MON_EN)
//   err_cnt  : saturating count of transfers with error     (ACCA_ERR_MON_EN)
//
// Optional build macro: ACCA_ERR_MON_EN adds the error monitor ports, an
// exact-product path carried alongside the pipeline, and the counters.
//
// Parameters: W operand width (even, 4..32); TRUNC truncated bits (0..W-1).
// ----------------------------------------------------------------------------
module acca_mul_pipe #(
    parameter int W     = 8,
    parameter int TRUNC = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    acca_mul_pipe_if.slave      bus
`ifdef ACCA_ERR_MON_EN
    ,
    input  logic                err_clr,
    output logic [31:0]         err_acc,
    output logic [15:0]         err_cnt
`endif
);

    localparam int H = W / 2;
    localparam logic [W-1:0] TMASK = {W{1'b1}} << TRUNC;

    logic             en;
    logic             v1_q, v2_q, v3_q;
    logic [W-1:0]     a_q, b_q;
    logic [3:0]       mode_q;
    logic [W-1:0]     hh_d, hl_d, lh_d, ll_d;
    logic [W-1:0]     hh_q, hl_q, lh_q, ll_q;
    logic [2*W:0]     sum_d;
    logic [2*W-1:0]   prod_d, prod_q;
    logic             sum_unused;

    // Single global enable: the whole pipe freezes only when a product is
    // waiting at the output and the consumer refuses it.
    assign en           = !(v3_q && !bus.out_ready);
    assign bus.in_ready = en;
    assign bus.out_valid = v3_q;
    assign bus.out_prod  = prod_q;

    function automatic logic [W-1:0] sub_mul(
        input logic [H-1:0] x,
        input logic [H-1:0] y,
        input logic         apx
    );
        logic [W-1:0] q;
        q = {{H{1'b0}}, x} * {{H{1'b0}}, y};
        return apx ? (q & TMASK) : q;
    endfunction

    // mode bit0 LL, bit1 LH (al*bh), bit2 HL (ah*bl), bit3 HH
    always_comb begin
        ll_d = sub_mul(a_q[H-1:0], b_q[H-1:0], mode_q[0]);
        lh_d = sub_mul(a_q[H-1:0], b_q[W-1:H], mode_q[1]);
        hl_d = sub_mul(a_q[W-1:H], b_q[H-1:0], mode_q[2]);
        hh_d = sub_mul(a_q[W-1:H], b_q[W-1:H], mode_q[3]);
    end

    // One spare bit of headroom; truncation never exceeds the exact product,
    // so the top bit is always zero and is simply dropped.
    always_comb begin
        sum_d = ({{(W+1){1'b0}}, hh_q} << W)
              + ({{(W+1){1'b0}}, hl_q} << H)
              + ({{(W+1){1'b0}}, lh_q} << H)
              +  {{(W+1){1'b0}}, ll_q};
        prod_d     = sum_d[2*W-1:0];
        sum_unused = sum_d[2*W];
    end

    // S1: operands and mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= '0;
        end else if (en) begin
            v1_q   <= bus.in_valid;
            a_q    <= bus.in_a;
            b_q    <= bus.in_b;
            mode_q <= bus.in_mode;
        end
    end

    // S2: approximated sub-products
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q <= 1'b0;
            hh_q <= '0;
            hl_q <= '0;
            lh_q <= '0;
            ll_q <= '0;
        end else if (en) begin
            v2_q <= v1_q;
            hh_q <= hh_d;
            hl_q <= hl_d;
            lh_q <= lh_d;
            ll_q <= ll_d;
        end
    end

    // S3: accumulated product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3_q   <= 1'b0;
            prod_q <= '0;
        end else if (en) begin
            v3_q   <= v2_q;
            prod_q <= prod_d;
        end
    end

`ifdef ACCA_ERR_MON_EN
    localparam int EW = (2 * W > 32) ? 2 * W : 32;
    localparam logic [EW:0] ACC_MAX = {{(EW-31){1'b0}}, 32'hFFFF_FFFF};

    logic [2*W-1:0]   exact_d, exact2_q, exact3_q, err_diff;
    logic [EW:0]      acc_sum;
    logic [31:0]      err_acc_d, err_acc_q;
    logic [15:0]      err_cnt_d, err_cnt_q;
    logic             out_xfer;

    assign exact_d  = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
    assign out_xfer = v3_q && bus.out_ready;
    assign err_acc  = err_acc_q;
    assign err_cnt  = err_cnt_q;

    // Exact product rides in lock-step with S2/S3 so it lines up with prod_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exact2_q <= '0;
            exact3_q <= '0;
        end else if (en) begin
            exact2_q <= exact_d;
            exact3_q <= exact2_q;
        end
    end

    always_comb begin
        err_diff  = exact3_q - prod_q;
        acc_sum   = {{(EW-31){1'b0}}, err_acc_q} + {{(EW+1-2*W){1'b0}}, err_diff};
        err_acc_d = err_acc_q;
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_acc_d = '0;
            err_cnt_d = '0;
        end else if (out_xfer) begin
            err_acc_d = (acc_sum > ACC_MAX) ? 32'hFFFF_FFFF : acc_sum[31:0];
            if (err_diff != '0 && err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_acc_q <= '0;
            err_cnt_q <= '0;
        end else begin
            err_acc_q <= err_acc_d;
            err_cnt_q <= err_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_acca_mul_pipe.sv
module tb_acca_mul_pipe;
    localparam int WA = 8;
    localparam int TA = 2;
    localparam int WB = 16;
    localparam int TB = 0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    acca_mul_pipe_if #(.W(WA)) ifa ();
    acca_mul_pipe_if #(.W(WB)) ifb ();

`ifdef ACCA_ERR_MON_EN
    logic        err_clr_a, err_clr_b;
    logic [31:0] err_acc_a, err_acc_b;
    logic [15:0] err_cnt_a, err_cnt_b;
`endif

    acca_mul_pipe #(.W(WA), .TRUNC(TA)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
`ifdef ACCA_ERR_MON_EN
        , .err_clr(err_clr_a), .err_acc(err_acc_a), .err_cnt(err_cnt_a)
`endif
    );

    acca_mul_pipe #(.W(WB), .TRUNC(TB)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
`ifdef ACCA_ERR_MON_EN
        , .err_clr(err_clr_b), .err_acc(err_acc_b), .err_cnt(err_cnt_b)
`endif
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [WA-1:0] a;
        logic [WA-1:0] b;
        logic [3:0]    mode;
    } tx_t;
    tx_t tx_q[$];

    // Model of DUT A: a three-slot delay line of (valid, approx, exact).
    bit              pv[3];
    logic [2*WA-1:0] pp[3];
    logic [2*WA-1:0] pe[3];
    longint          m_err_acc = 0;
    int              m_err_cnt = 0;

    function automatic longint apx(input longint q, input bit on);
        return on ? q - (q % (longint'(1) << TA)) : q;
    endfunction

    function automatic logic [2*WA-1:0] ref_a(input logic [WA-1:0] a,
                                              input logic [WA-1:0] b,
                                              input logic [3:0]    m);
        longint base, ah, al, bh, bl, s;
        base = longint'(1) << (WA / 2);
        ah = longint'(a) / base;
        al = longint'(a) % base;
        bh = longint'(b) / base;
        bl = longint'(b) % base;
        s  = apx(al * bl, m[0])
           + (apx(al * bh, m[1]) + apx(ah * bl, m[2])) * base
           + apx(ah * bh, m[3]) * base * base;
        return s[2*WA-1:0];
    endfunction

    function automatic logic [2*WA-1:0] exact_a(input logic [WA-1:0] a,
                                                input logic [WA-1:0] b);
        longint p;
        p = longint'(a) * longint'(b);
        return p[2*WA-1:0];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 3; i++) begin
            pv[i] = 1'b0;
            pp[i] = '0;
            pe[i] = '0;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", ifa.out_valid); end
        checks++; if (ifa.out_prod !== 16'h0) begin errors++; $display("FAIL reset out_prod: got %h want 0000", ifa.out_prod); end
        checks++; if (ifa.in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", ifa.in_ready); end
        checks++; if (ifb.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid_b: got %b want 0", ifb.out_valid); end
`ifdef ACCA_ERR_MON_EN
        checks++; if (err_acc_a !== 32'd0 || err_cnt_a !== 16'd0) begin errors++; $display("FAIL reset err: got %0d/%0d want 0/0", err_acc_a, err_cnt_a); end
`endif
    endtask

    // Single transaction, edge-counted: visible after 3 edges incl. acceptance.
    task automatic test_latency(input logic [3:0] mode, input logic [15:0] want);
        ifa.out_ready = 1'b1;
        ifa.in_valid  = 1'b1;
        ifa.in_a      = 8'hFF;
        ifa.in_b      = 8'hFF;
        ifa.in_mode   = mode;
        @(negedge clk);
        ifa.in_valid = 1'b0;
        ifa.in_a     = 8'h00;
        ifa.in_b     = 8'h00;
        checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL latency edge1: out_valid got %b want 0", ifa.out_valid); end
        @(negedge clk);
        checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL latency edge2: out_valid got %b want 0", ifa.out_valid); end
        @(negedge clk);
        checks++; if (ifa.out_valid !== 1'b1) begin errors++; $display("FAIL latency edge3: out_valid got %b want 1", ifa.out_valid); end
        checks++; if (ifa.out_prod !== want) begin errors++; $display("FAIL latency prod mode=%b: got %h want %h", mode, ifa.out_prod, want); end
        if (exact_a(8'hFF, 8'hFF) != want) begin
            m_err_acc = m_err_acc + longint'(exact_a(8'hFF, 8'hFF) - want);
            m_err_cnt++;
        end
        @(negedge clk);
        checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL latency drained: out_valid got %b want 0", ifa.out_valid); end
`ifdef ACCA_ERR_MON_EN
        checks++; if (err_acc_a !== 32'(m_err_acc) || err_cnt_a !== 16'(m_err_cnt)) begin
            errors++; $display("FAIL err_mon mode=%b: got %0d/%0d want %0d/%0d", mode, err_acc_a, err_cnt_a, m_err_acc, m_err_cnt);
        end
`endif
    endtask

    // Streams tx_q through DUT A. rdy_mode: 0 always ready, 1 stall window,
    // 2 random ready. gap_pct: chance of idling the input in a cycle.
    task automatic stream_a(input string tag, input int rdy_mode,
                            input int stall_at, input int stall_len, input int gap_pct);
        int  cyc, limit, sent, got, stall_seen;
        bit  r, en;
        cyc = 0; sent = 0; got = 0; stall_seen = 0;
        limit = 30 * tx_q.size() + 50;
        while ((tx_q.size() > 0 || pv[0] || pv[1] || pv[2]) && cyc < limit) begin
            checks++; if (ifa.out_valid !== pv[2]) begin errors++; $display("FAIL %s out_valid cyc%0d: got %b want %b", tag, cyc, ifa.out_valid, pv[2]); end
            if (pv[2]) begin
                checks++; if (ifa.out_prod !== pp[2]) begin errors++; $display("FAIL %s out_prod cyc%0d: got %h want %h", tag, cyc, ifa.out_prod, pp[2]); end
            end
            case (rdy_mode)
                0:       r = 1'b1;
                1:       r = !(cyc >= stall_at && cyc < stall_at + stall_len);
                default: r = ($urandom_range(0, 3) != 0);
            endcase
            ifa.out_ready = r;
            if (tx_q.size() > 0 && int'($urandom_range(0, 99)) >= gap_pct) begin
                ifa.in_valid = 1'b1;
                ifa.in_a     = tx_q[0].a;
                ifa.in_b     = tx_q[0].b;
                ifa.in_mode  = tx_q[0].mode;
            end else begin
                ifa.in_valid = 1'b0;
                ifa.in_a     = 8'($urandom);
                ifa.in_b     = 8'($urandom);
                ifa.in_mode  = 4'($urandom);
            end
            #1;
            en = !(pv[2] && !r);
            if (!en) stall_seen++;
            checks++; if (ifa.in_ready !== en) begin errors++; $display("FAIL %s in_ready cyc%0d: got %b want %b", tag, cyc, ifa.in_ready, en); end
            if (pv[2] && r) begin
                got++;
                if (pe[2] != pp[2]) begin
                    m_err_acc = m_err_acc + longint'(pe[2] - pp[2]);
                    if (m_err_acc > 64'hFFFF_FFFF) m_err_acc = 64'hFFFF_FFFF;
                    if (m_err_cnt < 65535) m_err_cnt++;
                end
            end
            if (en) begin
                pv[2] = pv[1]; pp[2] = pp[1]; pe[2] = pe[1];
                pv[1] = pv[0]; pp[1] = pp[0]; pe[1] = pe[0];
                pv[0] = ifa.in_valid;
                pp[0] = ref_a(ifa.in_a, ifa.in_b, ifa.in_mode);
                pe[0] = exact_a(ifa.in_a, ifa.in_b);
                if (ifa.in_valid) begin
                    void'(tx_q.pop_front());
                    sent++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        ifa.in_valid  = 1'b0;
        ifa.out_ready = 1'b1;
        if (cyc >= limit) begin
            checks++; errors++;
            $display("FAIL %s timeout: got %0d cycles want < %0d", tag, cyc, limit);
        end
        checks++; if (got !== sent) begin errors++; $display("FAIL %s count: got %0d results want %0d", tag, got, sent); end
        if (rdy_mode == 1) begin
            checks++; if (stall_seen < stall_len) begin errors++; $display("FAIL %s stall: got %0d stalled cycles want >= %0d", tag, stall_seen, stall_len); end
        end
`ifdef ACCA_ERR_MON_EN
        checks++; if (err_acc_a !== 32'(m_err_acc) || err_cnt_a !== 16'(m_err_cnt)) begin
            errors++; $display("FAIL %s err_mon: got %0d/%0d want %0d/%0d", tag, err_acc_a, err_cnt_a, m_err_acc, m_err_cnt);
        end
`endif
    endtask

    task automatic test_directed();
        tx_t t;
        t.a = 8'h13; t.b = 8'h25; t.mode = 4'b0001; tx_q.push_back(t);
        t.mode = 4'b0000; tx_q.push_back(t);
        stream_a("directed", 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        tx_t t;
        for (int i = 0; i < 5; i++) begin
            t.a = 8'($urandom); t.b = 8'($urandom); t.mode = 4'($urandom);
            tx_q.push_back(t);
        end
        stream_a("back_to_back", 1, 3, 4, 0);
    endtask

    task automatic test_random_a();
        tx_t t;
        for (int i = 0; i < 200; i++) begin
            t.a = 8'($urandom); t.b = 8'($urandom); t.mode = 4'($urandom);
            tx_q.push_back(t);
        end
        stream_a("random_a", 2, 0, 0, 20);
    endtask

    task automatic test_reset_midflight();
        ifa.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ifa.in_valid = 1'b1;
            ifa.in_a     = 8'($urandom | 1);
            ifa.in_b     = 8'($urandom | 1);
            ifa.in_mode  = 4'($urandom);
            @(negedge clk);
        end
        ifa.in_valid = 1'b0;
        checks++; if (ifa.out_valid !== 1'b1) begin errors++; $display("FAIL midflight pre: out_valid got %b want 1", ifa.out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL midflight async out_valid: got %b want 0", ifa.out_valid); end
        checks++; if (ifa.out_prod !== 16'h0) begin errors++; $display("FAIL midflight async out_prod: got %h want 0000", ifa.out_prod); end
        clear_model();
        m_err_acc = 0;
        m_err_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL midflight stale cyc%0d: out_valid got %b want 0", i, ifa.out_valid); end
            checks++; if (ifa.in_ready !== 1'b1) begin errors++; $display("FAIL midflight in_ready cyc%0d: got %b want 1", i, ifa.in_ready); end
        end
`ifdef ACCA_ERR_MON_EN
        checks++; if (err_acc_a !== 32'd0 || err_cnt_a !== 16'd0) begin errors++; $display("FAIL midflight err: got %0d/%0d want 0/0", err_acc_a, err_cnt_a); end
`endif
    endtask

    task automatic test_exact_w16();
        logic [2*WB-1:0] exp_q[$];
        logic [2*WB-1:0] e;
        int sent, got, cyc;
        sent = 0; got = 0; cyc = 0;
        while ((sent < 1000 || exp_q.size() > 0) && cyc < 6000) begin
            ifb.out_ready = ($urandom_range(0, 3) != 0);
            if (sent < 1000) begin
                ifb.in_valid = 1'b1;
                ifb.in_a     = 16'($urandom);
                ifb.in_b     = 16'($urandom);
                ifb.in_mode  = 4'($urandom_range(0, 15));
            end else begin
                ifb.in_valid = 1'b0;
            end
            #1;
            if (ifb.out_valid && ifb.out_ready) begin
                got++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL exact_w16 extra output: got %h want none", ifb.out_prod);
                end else begin
                    e = exp_q.pop_front();
                    if (ifb.out_prod !== e) begin errors++; $display("FAIL exact_w16 #%0d: got %h want %h", got, ifb.out_prod, e); end
                end
            end
            if (ifb.in_valid && ifb.in_ready) begin
                exp_q.push_back(32'(longint'(ifb.in_a) * longint'(ifb.in_b)));
                sent++;
            end
            @(negedge clk);
            cyc++;
        end
        ifb.in_valid  = 1'b0;
        ifb.out_ready = 1'b1;
        checks++; if (got !== 1000) begin errors++; $display("FAIL exact_w16 count: got %0d want 1000", got); end
    endtask

    initial begin
        rst_n = 1'b0;
        ifa.in_valid = 1'b0; ifa.in_a = '0; ifa.in_b = '0; ifa.in_mode = '0; ifa.out_ready = 1'b1;
        ifb.in_valid = 1'b0; ifb.in_a = '0; ifb.in_b = '0; ifb.in_mode = '0; ifb.out_ready = 1'b1;
`ifdef ACCA_ERR_MON_EN
        err_clr_a = 1'b0;
        err_clr_b = 1'b0;
`endif
        clear_model();
        test_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_latency(4'b0000, 16'hFE01);
        test_latency(4'b1111, 16'hFCE0);
        test_directed();
        test_back_to_back();
        test_random_a();
        test_reset_midflight();
        test_exact_w16();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion want finish before 2ms");
        $fatal(1, "watchdog expired");
    end
endmodule
